// File: rtl/data_memory_param.sv
// Byte-addressed big-endian data memory with a valid/ready request port and a one-pulse response.
// Stores respond one cycle after accept; loads respond READ_LATENCY cycles after accept.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are rejected with rsp_error instead of split bytewise.
module data_memory_param #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [1:0]      r_cnt;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [63:0]     r_rsp_rdata;
  logic            r_rsp_error;
  logic [63:0]     r_pend_rdata;
  logic            r_pend_error;
  logic [7:0]      r_mem [DEPTH];

  logic            w_accept;
  logic [3:0]      w_nbytes;
  logic            w_misaligned;
  logic            w_block;
  logic [63:0]     w_raw;
  logic [63:0]     w_ext;
  logic [63:0]     w_rdata;
  logic [ADDR_WIDTH-1:0] w_byte_addr;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

  assign w_accept     = req_valid && r_req_ready;
  assign w_nbytes     = 4'd1 << req_size;
  // Aligned means the low address bits below the access size are all zero.
  assign w_misaligned = (req_addr[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_block = w_misaligned;
`else
  assign w_block = 1'b0;
`endif

  // Gather the addressed bytes, first byte most significant, wrapping at the top of memory.
  always_comb begin
    w_raw       = '0;
    w_byte_addr = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(w_nbytes)) begin
        w_byte_addr = req_addr + ADDR_WIDTH'(i);
        w_raw       = {w_raw[55:0], r_mem[w_byte_addr]};
      end
    end
  end

  // Sign/zero-extend to 64 bits; stores and trapped accesses return zero.
  always_comb begin
    case (req_size)
      2'b00:   w_ext = req_unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      2'b01:   w_ext = req_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      2'b10:   w_ext = req_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      default: w_ext = w_raw;
    endcase
    w_rdata = (req_write || w_block) ? 64'd0 : w_ext;
  end

  // Store commit on the accept edge; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_accept && req_write && !w_block) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(w_nbytes)) begin
          r_mem[req_addr + ADDR_WIDTH'(i)] <= req_wdata[8*(int'(w_nbytes)-1-i) +: 8];
        end
      end
    end
  end

  // Request/response FSM; response fields only change when the valid pulse is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 64'd0;
      r_rsp_error  <= 1'b0;
      r_pend_rdata <= 64'd0;
      r_pend_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_pend_rdata <= w_rdata;
            r_pend_error <= w_block;
            if (!req_write && (READ_LATENCY > 1)) begin
              r_state <= WAIT;
              r_cnt   <= 2'(READ_LATENCY - 2);
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata;
              r_rsp_error <= w_block;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pend_rdata;
            r_rsp_error <= r_pend_error;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: a READ_LATENCY=3 instance checked against a byte-array model,
// plus a READ_LATENCY=2 instance used for reset-during-flight behaviour.
module tb_data_memory_param;

  localparam int LAT = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        reset, req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_error;

  // second instance
  logic        rst2, v2, rdy2, w2, u2, rv2, er2;
  logic [1:0]  sz2;
  logic [7:0]  a2;
  logic [63:0] wd2, rd2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [256];
  logic [63:0] got_rd;

  data_memory_param #(.ADDR_WIDTH(8), .READ_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_memory_param #(.ADDR_WIDTH(8), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst2), .req_valid(v2), .req_ready(rdy2),
    .req_write(w2), .req_size(sz2), .req_unsigned(u2),
    .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2),
    .rsp_rdata(rd2), .rsp_error(er2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mis(input int sz, input int a);
    return (a % (1 << sz)) != 0;
  endfunction

  // Model value of a load: big-endian number read from consecutive (wrapping) bytes.
  function automatic logic [63:0] model_load(input int sz, input bit uns, input int a);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'd0;
    if (TRAP && mis(sz, a)) return 64'd0;
    for (int i = 0; i < n; i++) v = v * 256 + 64'(ref_mem[(a + i) % 256]);
    if (!uns && n < 8 && v >= (64'd1 << (8*n - 1))) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  task automatic model_store(input int sz, input int a, input logic [63:0] wd);
    int n;
    n = 1 << sz;
    if (TRAP && mis(sz, a)) return;
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  // One transaction on the main instance; starts and ends at a negedge.
  task automatic do_req(input bit w, input int sz, input bit u, input int a,
                        input logic [63:0] wd, input string tag, output logic [63:0] rd);
    int exp_lat, k, guard;
    logic [63:0] exp_rd;
    bit exp_er;
    exp_lat = w ? 1 : LAT;
    exp_rd  = w ? 64'd0 : model_load(sz, u, a);
    exp_er  = TRAP && mis(sz, a);
    if (w) model_store(sz, a, wd);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    chk({tag, "/ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_size = 2'(sz); req_unsigned = u;
    req_addr = 8'(a); req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    // inputs after accept must not matter
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = 8'($urandom); req_wdata = {$urandom, $urandom};
    k = 1;
    while (!rsp_valid && k < 8) begin
      chk({tag, "/ready_busy"}, 64'(req_ready), 64'd0);
      @(negedge clk);
      k++;
    end
    chk({tag, "/latency"}, rsp_valid ? 64'(k) : 64'd0, 64'(exp_lat));
    chk({tag, "/ready_rsp"}, 64'(req_ready), 64'd0);
    chk({tag, "/rdata"}, rsp_rdata, exp_rd);
    chk({tag, "/error"}, 64'(rsp_error), 64'(exp_er));
    rd = rsp_rdata;
    @(negedge clk);
    chk({tag, "/valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, "/rdata_hold"}, rsp_rdata, exp_rd);
    chk({tag, "/ready_back"}, 64'(req_ready), 64'd1);
  endtask

  // One transaction on the second instance.
  task automatic req2(input bit w, input int sz, input int a, input logic [63:0] wd,
                      output logic [63:0] rd);
    int k;
    v2 = 1'b1; w2 = w; sz2 = 2'(sz); u2 = 1'b1; a2 = 8'(a); wd2 = wd;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    k = 1;
    while (!rv2 && k < 8) begin @(negedge clk); k++; end
    chk("dut2/latency", rv2 ? 64'(k) : 64'd0, w ? 64'd1 : 64'd2);
    rd = rd2;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz, a;
    bit w, u;
    logic [63:0] wd;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 8'd0; req_wdata = 64'd0;
    rst2 = 1'b1; v2 = 1'b0; w2 = 1'b0; sz2 = 2'd0; u2 = 1'b0; a2 = 8'd0; wd2 = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/ready", 64'(req_ready), 64'd1);
    chk("reset/valid", 64'(rsp_valid), 64'd0);
    chk("reset/rdata", rsp_rdata, 64'd0);
    chk("reset/error", 64'(rsp_error), 64'd0);
    reset = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // fill memory so every later read is defined
    for (int i = 0; i < 256; i += 8) do_req(1'b1, 3, 1'b0, i, {$urandom, $urandom}, "init", got_rd);

    // big-endian double store/load
    do_req(1'b1, 3, 1'b0, 8'h10, 64'h0102030405060708, "st_d10", got_rd);
    do_req(1'b0, 3, 1'b0, 8'h10, 64'd0, "ld_d10", got_rd);
    chk("dir/ld_d10", got_rd, 64'h0102030405060708);
    do_req(1'b0, 0, 1'b1, 8'h10, 64'd0, "ld_b10", got_rd);
    chk("dir/ld_b10", got_rd, 64'h01);
    do_req(1'b0, 0, 1'b1, 8'h17, 64'd0, "ld_b17", got_rd);
    chk("dir/ld_b17", got_rd, 64'h08);

    // sign and zero extension
    do_req(1'b1, 0, 1'b0, 8'h20, 64'h80, "st_b20", got_rd);
    do_req(1'b0, 0, 1'b0, 8'h20, 64'd0, "ld_b20s", got_rd);
    chk("dir/ld_b20s", got_rd, 64'hFFFFFFFFFFFFFF80);
    do_req(1'b0, 0, 1'b1, 8'h20, 64'd0, "ld_b20u", got_rd);
    chk("dir/ld_b20u", got_rd, 64'h0000000000000080);

`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b1, 2, 1'b0, 8'h02, 64'h11223344, "st_w02", got_rd);
    chk("dir/st_w02_err", 64'(rsp_error), 64'd1);
    do_req(1'b0, 3, 1'b1, 8'h00, 64'd0, "ld_d00", got_rd);
`else
    do_req(1'b1, 3, 1'b0, 8'hFC, 64'hAABBCCDDEEFF0011, "st_dFC", got_rd);
    do_req(1'b0, 0, 1'b1, 8'hFF, 64'd0, "ld_bFF", got_rd);
    chk("dir/ld_bFF", got_rd, 64'hDD);
    do_req(1'b0, 0, 1'b1, 8'h00, 64'd0, "ld_b00", got_rd);
    chk("dir/ld_b00", got_rd, 64'hEE);
`endif

    // random traffic against the model
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom);
      sz = int'($urandom_range(0, 3));
      u  = 1'($urandom);
      a  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a = a & ~((1 << sz) - 1);
      wd = {$urandom, $urandom};
      do_req(w, sz, u, a, wd, "rand", got_rd);
    end

    // reset while a latency-2 load is in flight
    req2(1'b1, 0, 8'h40, 64'h5A, got_rd);
    req2(1'b0, 0, 8'h40, 64'd0, got_rd);
    chk("dut2/ld_40", got_rd, 64'h5A);
    v2 = 1'b1; w2 = 1'b0; sz2 = 2'd0; u2 = 1'b1; a2 = 8'h40;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0; rst2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("dut2/rst_valid", 64'(rv2), 64'd0);
    chk("dut2/rst_ready", 64'(rdy2), 64'd1);
    chk("dut2/rst_rdata", rd2, 64'd0);
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dut2/no_pulse", 64'(rv2), 64'd0);
    end
    // store presented on a reset edge must not commit
    v2 = 1'b1; w2 = 1'b1; sz2 = 2'd0; a2 = 8'h40; wd2 = 64'hA5; rst2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("dut2/rst_store_valid", 64'(rv2), 64'd0);
    req2(1'b0, 0, 8'h40, 64'd0, got_rd);
    chk("dut2/mem_kept", got_rd, 64'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 The block SHALL expose these parameters:
- ADDR_WIDTH, default 8: byte-address width; memory holds 2**ADDR_WIDTH bytes.
- READ_LATENCY, default 1, legal 1..4: cycles from read accept to rsp_valid.
REQ-002 The block SHALL expose these ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  64  store data; low 8/16/32/64 bits used per size.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  64  load result; 0 for stores and errors.
- rsp_error  out  1  qualified by rsp_valid; misaligned access flagged.

Function
REQ-003 Byte order SHALL be big-endian: the most significant byte of an N-byte access is at req_addr and the least significant byte is at req_addr+N-1.
REQ-004 A request SHALL be accepted on a posedge where req_valid and req_ready are both 1; only one request SHALL be outstanding at a time.
REQ-005 FSM states SHALL be IDLE, WAIT and RESP.
- In IDLE, req_ready = 1; in WAIT and RESP, req_ready = 0.
- IDLE -> WAIT on an accepted read with READ_LATENCY > 1.
- IDLE -> RESP on an accepted write, or on an accepted read with READ_LATENCY = 1.
- WAIT -> RESP when the latency counter reaches 0.
- RESP -> IDLE unconditionally.
REQ-006 A store SHALL commit all of its bytes on the accept edge; rsp_valid SHALL be 1 exactly one cycle after accept, with rsp_rdata = 0.
REQ-007 A load SHALL snapshot its bytes on the accept edge; rsp_valid SHALL be 1 exactly READ_LATENCY cycles after accept and low at all other times.
REQ-008 Load results narrower than 64 bits SHALL be sign- or zero-extended to 64 bits according to req_unsigned; for size 11, req_unsigned SHALL be ignored.
REQ-009 req_size, req_unsigned, req_addr and req_wdata SHALL be captured on accept; changes to these inputs after accept SHALL have no effect.
REQ-010 Byte addresses SHALL wrap modulo 2**ADDR_WIDTH (for example, a double access at 0xFC touches 0xFC..0xFF and then 0x00..0x03) unless REQ-014 applies.
REQ-011 req_valid asserted while req_ready = 0 SHALL be ignored; the requester holds the request until it is accepted.
REQ-012 rsp_rdata and rsp_error SHALL hold their last values when rsp_valid = 0.

Reset
REQ-013 While reset = 1 on a posedge:
- FSM returns to IDLE; the latency counter clears to 0.
- Outputs: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
- Any in-flight response is discarded.
- Memory contents are not modified; a store accepted on the same edge as reset SHALL NOT commit.

Configuration
REQ-014 Macro DMEM_MISALIGN_TRAP_EN:
- Defined: an access whose address is not a multiple of its size SHALL write no bytes, return rsp_rdata = 0 and rsp_error = 1, with the same latency as an aligned access of the same type.
- Undefined: misaligned accesses SHALL be performed bytewise with wrap per REQ-010, and rsp_error SHALL always be 0.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Store double 0x0102030405060708 @0x10, then load double @0x10 -> rsp_rdata = 0x0102030405060708; byte @0x10 = 0x01; byte @0x17 = 0x08.
- With mem[0x20] = 0x80: load byte signed @0x20 -> 0xFFFFFFFFFFFFFF80; load byte unsigned @0x20 -> 0x0000000000000080.
- READ_LATENCY = 3: load accepted at cycle 0 -> rsp_valid high only in cycle 3; req_ready low in cycles 1-3.
- Trap macro defined: store word @0x02 -> rsp_error = 1, memory unchanged. Undefined: store double 0xAABBCCDDEEFF0011 @0xFC -> mem[0xFF] = 0xDD and mem[0x00] = 0xEE.
- Reset asserted one cycle after a READ_LATENCY = 2 load is accepted -> no rsp_valid pulse; req_ready = 1 after reset; memory unchanged.
